// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] aorig_q, aorig_d;
  logic        div_q, div_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        bz_q, bz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  function automatic logic [31:0] abs32(input logic signed [31:0] x);
    return x[31] ? -x : x;
  endfunction

  function automatic logic [31:0] neg32(input logic signed [31:0] x);
    return -x;
  endfunction

  function automatic logic [63:0] neg64(input logic signed [63:0] x);
    return -x;
  endfunction

  logic [31:0] a_mag, b_mag;
  assign a_mag = op[0] ? a : abs32(a);
  assign b_mag = op[0] ? b : abs32(b);

  // Multiply step: conditionally add multiplicand to the upper half, shift right.
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_step = {mul_sum, acc_q[31:1]};

  // Divide step: acc holds {remainder, dividend bits}; quotient bits enter at the bottom.
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [63:0] div_step;
  assign rem_sh   = {acc_q[63:32], acc_q[31]};
  assign rem_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_sub  = rem_sh[31:0] - opnd_q;
  assign div_step = rem_ge ? {rem_sub, acc_q[30:0], 1'b1}
                           : {rem_sh[31:0], acc_q[30:0], 1'b0};

  logic [63:0] mul_fix;
  assign mul_fix = (sa_q ^ sb_q) ? neg64(acc_q) : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    aorig_d = aorig_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!op[2]) begin
            div_d   = op[1];
            sa_d    = ~op[0] & a[31];
            sb_d    = ~op[0] & b[31];
            aorig_d = a;
            bz_d    = (b == 32'd0);
            cnt_d   = 5'd0;
            state_d = CALC;
            if (op[1]) begin
              acc_d  = {32'd0, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {32'd0, b_mag};
              opnd_d = a_mag;
            end
          end else if (!op[1]) begin
            if (op[0]) lo_d = a;
            else       hi_d = a;
          end
        end
      end
      CALC: begin
        acc_d = div_q ? div_step : mul_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (!div_q) begin
          hi_d = mul_fix[63:32];
          lo_d = mul_fix[31:0];
        end else if (bz_q) begin
          hi_d = aorig_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          lo_d = (sa_q ^ sb_q) ? neg32(acc_q[31:0]) : acc_q[31:0];
          hi_d = sa_q ? neg32(acc_q[63:32]) : acc_q[63:32];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    opnd_q  <= opnd_d;
    aorig_q <= aorig_d;
    div_q   <= div_d;
    sa_q    <= sa_d;
    sb_q    <= sb_d;
    bz_q    <= bz_d;
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
